// File: rtl/cpu_bus_arbiter.sv
// Two-master round-robin arbiter that turns each grant into one address beat on the shared bus,
// captures read data after ReadLatency cycles and returns it with a one-cycle ack.
module cpu_bus_arbiter #(
   parameter int unsigned address_width = 32,
   parameter int unsigned ReadLatency   = 1
) (
   input  logic                     clk_i,
   input  logic                     reset_ni,
   input  logic                     halt_i,
   input  logic                     m0_req_i,
   input  logic [address_width-1:0] m0_addr_i,
   input  logic [31:0]              m0_wdata_i,
   input  logic [3:0]               m0_strb_i,
   output logic                     m0_ack_o,
   output logic [31:0]              m0_rdata_o,
   input  logic                     m1_req_i,
   input  logic [address_width-1:0] m1_addr_i,
   input  logic [31:0]              m1_wdata_i,
   input  logic [3:0]               m1_strb_i,
   output logic                     m1_ack_o,
   output logic [31:0]              m1_rdata_o,
   output logic [address_width-1:0] address_o,
   output logic [31:0]              data_o,
   output logic [3:0]               we_ram_o,
   output logic                     we_o,
   input  logic [31:0]              data_i,
   output logic [1:0]               grant_o,
   output logic                     busy_o
);

   typedef enum logic [1:0] {StIdle, StAddr, StWait, StDone} state_e;

   localparam logic [3:0] CntLoad = 4'(ReadLatency - 1);

   state_e                     state_q, state_d;
   logic [3:0]                 cnt_q, cnt_d;
   logic                       last_q, last_d;
   logic [1:0]                 grant_q, grant_d;
   logic [1:0]                 ack_q, ack_d;
   logic [address_width-1:0]   addr_q, addr_d;
   logic [31:0]                wdata_q, wdata_d;
   logic [31:0]                rdata_q, rdata_d;
   logic [3:0]                 strb_q, strb_d;
   logic                       sel;
   logic                       beat;

   // Master 1 wins when it asks alone, or on a tie when master 0 was served last.
   assign sel = m1_req_i & (~m0_req_i | ~last_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      grant_d = grant_q;
      ack_d   = '0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      strb_d  = strb_q;
      unique case (state_q)
         StIdle: begin
            if (!halt_i && (m0_req_i || m1_req_i)) begin
               grant_d = sel ? 2'b10 : 2'b01;
               last_d  = sel;
               addr_d  = sel ? m1_addr_i : m0_addr_i;
               wdata_d = sel ? m1_wdata_i : m0_wdata_i;
               strb_d  = sel ? m1_strb_i : m0_strb_i;
               state_d = StAddr;
            end
         end
         StAddr: begin
            cnt_d   = CntLoad;
            state_d = (ReadLatency == 1) ? StDone : StWait;
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = StDone;
            end
         end
         StDone: begin
            rdata_d = data_i;
            ack_d   = grant_q;
            grant_d = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         last_q  <= 1'b1;
         grant_q <= '0;
         ack_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         strb_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         strb_q  <= strb_d;
      end
   end

   // Bus and read-data outputs are gated so they are zero outside their windows.
   assign beat       = (state_q == StAddr);
   assign address_o  = beat ? addr_q : '0;
   assign data_o     = beat ? wdata_q : '0;
   assign we_ram_o   = beat ? strb_q : '0;
   assign we_o       = |we_ram_o;
   assign grant_o    = grant_q;
   assign busy_o     = (state_q != StIdle);
   assign m0_ack_o   = ack_q[0];
   assign m1_ack_o   = ack_q[1];
   assign m0_rdata_o = ack_q[0] ? rdata_q : '0;
   assign m1_rdata_o = ack_q[1] ? rdata_q : '0;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: instance 0 uses ReadLatency 1, instance 1 uses ReadLatency 4, both
// driven by the same masters and bus, checked against a transaction-level timing model.
module tb_cpu_bus_arbiter;

   localparam int AW = 32;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic halt = 1'b0;
   logic m0_req = 1'b0, m1_req = 1'b0;
   logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0, data_in = '0;
   logic [3:0] m0_strb = '0, m1_strb = '0;

   logic [1:0][31:0] address_w, data_w, m0_rdata_w, m1_rdata_w;
   logic [1:0][3:0]  we_ram_w;
   logic [1:0][1:0]  grant_w;
   logic [1:0]       we_w, m0_ack_w, m1_ack_w, busy_w;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      cpu_bus_arbiter #(.address_width(AW), .ReadLatency(k == 0 ? 1 : 4)) u_dut (
         .clk_i(clk), .reset_ni(reset_n), .halt_i(halt),
         .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_strb_i(m0_strb),
         .m0_ack_o(m0_ack_w[k]), .m0_rdata_o(m0_rdata_w[k]),
         .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_strb_i(m1_strb),
         .m1_ack_o(m1_ack_w[k]), .m1_rdata_o(m1_rdata_w[k]),
         .address_o(address_w[k]), .data_o(data_w[k]), .we_ram_o(we_ram_w[k]), .we_o(we_w[k]),
         .data_i(data_in), .grant_o(grant_w[k]), .busy_o(busy_w[k])
      );
   end

   always #5 clk = ~clk;

   int checks = 0, errors = 0, cyc = 0;

   // Transaction-level model: one record per instance, timed from its address-beat cycle.
   bit          act[2];
   int          own[2], a_cyc[2], last[2];
   logic [31:0] t_addr[2], t_wdata[2], cap[2];
   logic [3:0]  t_strb[2];
   logic [31:0] e_addr[2], e_data[2], e_rd[2];
   logic [3:0]  e_strb[2];
   logic [1:0]  e_grant[2], e_ack[2];
   bit          e_busy[2], e_rdchk[2];

   function automatic int rl_of(int k);
      return (k == 0) ? 1 : 4;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         act[k] = 0; last[k] = 1;
         e_addr[k] = '0; e_data[k] = '0; e_rd[k] = '0; e_strb[k] = '0;
         e_grant[k] = '0; e_ack[k] = '0; e_busy[k] = 0; e_rdchk[k] = 0;
      end
   endtask

   // Called mid-cycle with this cycle's inputs applied; predicts the next cycle's outputs.
   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int rl, sel;
         bit idle;
         rl = rl_of(k);
         idle = !act[k] || (cyc >= a_cyc[k] + rl + 1);
         if (act[k] && cyc == a_cyc[k] + rl) cap[k] = data_in;
         e_ack[k] = '0; e_rd[k] = '0; e_rdchk[k] = 0;
         if (act[k] && cyc + 1 == a_cyc[k] + rl + 1) begin
            e_ack[k][own[k]] = 1'b1;
            e_rd[k] = cap[k];
            e_rdchk[k] = (t_strb[k] == 4'd0);
         end
         if (idle && !halt && (m0_req || m1_req)) begin
            if (m0_req && m1_req) sel = 1 - last[k];
            else sel = m1_req ? 1 : 0;
            act[k] = 1; own[k] = sel; a_cyc[k] = cyc + 1; last[k] = sel;
            t_addr[k]  = sel ? m1_addr : m0_addr;
            t_wdata[k] = sel ? m1_wdata : m0_wdata;
            t_strb[k]  = sel ? m1_strb : m0_strb;
         end
         e_addr[k] = '0; e_data[k] = '0; e_strb[k] = '0; e_grant[k] = '0; e_busy[k] = 0;
         if (act[k] && cyc + 1 == a_cyc[k]) begin
            e_addr[k] = t_addr[k]; e_data[k] = t_wdata[k]; e_strb[k] = t_strb[k];
         end
         if (act[k] && cyc + 1 >= a_cyc[k] && cyc + 1 <= a_cyc[k] + rl) begin
            e_grant[k] = (own[k] == 1) ? 2'b10 : 2'b01;
            e_busy[k] = 1;
         end
      end
   endtask

   task automatic run_cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      m0_req = 0; m1_req = 0; halt = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         run_cycle();
         if (busy_w == 2'b00 && m0_ack_w == 2'b00 && m1_ack_w == 2'b00) ok = 1;
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL wait_idle: busy=%b still set, required 00", busy_w); end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      model_reset();
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({address_w[k], data_w[k], we_ram_w[k], we_w[k], grant_w[k], busy_w[k], m0_ack_w[k],
              m1_ack_w[k], m0_rdata_w[k], m1_rdata_w[k]} !== '0) begin
            errors++; $display("FAIL reset_outputs inst%0d: got nonzero outputs, required all 0", k);
         end
      end
      m0_req = 1; m0_addr = 32'h44;
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (busy_w[k] !== 1'b0 || address_w[k] !== '0) begin
            errors++;
            $display("FAIL reset_hold inst%0d: busy=%b addr=%h, required 0 0", k, busy_w[k],
                     address_w[k]);
         end
      end
      m0_req = 0;
      reset_n = 1'b1;
      cyc = 0;
   endtask

   task automatic test_read_rl1();
      int a = -1, beats = 0;
      bit got = 0, m1_seen = 0;
      m0_addr = 32'h100; m0_strb = 4'h0; m0_wdata = '0; data_in = 32'hDEADBEEF; m0_req = 1;
      for (int i = 0; i < 12 && !got; i++) begin
         run_cycle();
         if (address_w[0] != '0) begin
            beats++;
            if (a < 0) a = cyc;
            checks++;
            if (address_w[0] !== 32'h100) begin
               errors++; $display("FAIL read_addr: got %h required 00000100", address_w[0]);
            end
         end
         if (m1_ack_w[0]) m1_seen = 1;
         if (m0_ack_w[0]) begin
            got = 1; m0_req = 0;
            checks++;
            if (cyc !== a + 2) begin
               errors++; $display("FAIL read_ack_cycle: got A+%0d required A+2", cyc - a);
            end
            checks++;
            if (m0_rdata_w[0] !== 32'hDEADBEEF) begin
               errors++; $display("FAIL read_rdata: got %h required deadbeef", m0_rdata_w[0]);
            end
         end
      end
      checks++;
      if (!got || beats != 1 || m1_seen) begin
         errors++;
         $display("FAIL read_summary: ack=%0d beats=%0d m1_ack=%0d, required 1 1 0", got, beats,
                  m1_seen);
      end
      wait_idle();
   endtask

   task automatic test_write_m1();
      int a = -1, beats = 0;
      bit got = 0, m0_seen = 0;
      m1_addr = 32'h2000; m1_wdata = 32'h12345678; m1_strb = 4'hF; m1_req = 1;
      for (int i = 0; i < 12 && !got; i++) begin
         run_cycle();
         if ({address_w[0], data_w[0], we_ram_w[0], we_w[0]} != '0) begin
            beats++;
            if (a < 0) a = cyc;
            checks++;
            if (address_w[0] !== 32'h2000 || data_w[0] !== 32'h12345678 || we_ram_w[0] !== 4'hF ||
                we_w[0] !== 1'b1) begin
               errors++;
               $display("FAIL write_beat: got %h %h %h %b required 00002000 12345678 f 1",
                        address_w[0], data_w[0], we_ram_w[0], we_w[0]);
            end
         end
         if (m0_ack_w[0]) m0_seen = 1;
         if (m1_ack_w[0]) begin
            got = 1; m1_req = 0;
            checks++;
            if (cyc !== a + 2) begin
               errors++; $display("FAIL write_ack_cycle: got A+%0d required A+2", cyc - a);
            end
         end
      end
      checks++;
      if (!got || beats != 1 || m0_seen) begin
         errors++;
         $display("FAIL write_summary: ack=%0d beats=%0d m0_ack=%0d, required 1 1 0", got, beats,
                  m0_seen);
      end
      m1_strb = 4'h0;
      wait_idle();
   endtask

   task automatic test_back_to_back();
      int n[2] = '{0, 0};
      int prev[2];
      m0_addr = 32'h10; m1_addr = 32'h20; m0_strb = '0; m1_strb = '0;
      m0_req = 1; m1_req = 1;
      for (int i = 0; i < 40 && n[0] < 6; i++) begin
         run_cycle();
         for (int k = 0; k < 2; k++) begin
            if (address_w[k] != '0) begin
               logic [1:0] eg;
               eg = (n[k] % 2 == 0) ? 2'b01 : 2'b10;
               checks++;
               if (grant_w[k] !== eg || address_w[k] !== ((eg == 2'b01) ? 32'h10 : 32'h20)) begin
                  errors++;
                  $display("FAIL b2b_grant inst%0d beat%0d: got %b %h required %b", k, n[k],
                           grant_w[k], address_w[k], eg);
               end
               if (n[k] > 0) begin
                  checks++;
                  if (cyc - prev[k] != rl_of(k) + 2) begin
                     errors++;
                     $display("FAIL b2b_spacing inst%0d: got %0d required %0d", k, cyc - prev[k],
                              rl_of(k) + 2);
                  end
               end
               prev[k] = cyc;
               n[k]++;
            end
         end
      end
      checks++;
      if (n[0] != 6 || n[1] < 2) begin
         errors++; $display("FAIL b2b_count: got %0d/%0d beats required 6/>=2", n[0], n[1]);
      end
      wait_idle();
   endtask

   task automatic test_rl4();
      logic [31:0] base = 32'hC0DE0000;
      int a = -1;
      bit acked = 0, second = 0;
      m0_addr = 32'h300; m0_strb = '0; m0_req = 1;
      for (int i = 0; i < 20 && !second; i++) begin
         data_in = base + 32'(cyc);
         run_cycle();
         if (address_w[1] != '0) begin
            if (a < 0) a = cyc;
            else begin
               second = 1;
               checks++;
               if (cyc != a + 6) begin
                  errors++; $display("FAIL rl4_next_beat: got A+%0d required A+6", cyc - a);
               end
            end
         end
         if (a >= 0 && cyc > a && cyc <= a + 4) begin
            checks++;
            if (busy_w[1] !== 1'b1 || grant_w[1] !== 2'b01) begin
               errors++;
               $display("FAIL rl4_busy A+%0d: got %b %b required 1 01", cyc - a, busy_w[1],
                        grant_w[1]);
            end
         end
         if (m0_ack_w[1]) begin
            acked = 1;
            checks++;
            if (cyc != a + 5 || m0_rdata_w[1] !== base + 32'(a + 4)) begin
               errors++;
               $display("FAIL rl4_ack: got A+%0d data %h required A+5 data %h", cyc - a,
                        m0_rdata_w[1], base + 32'(a + 4));
            end
            checks++;
            if (busy_w[1] !== 1'b0 || grant_w[1] !== 2'b00) begin
               errors++;
               $display("FAIL rl4_ack_idle: got %b %b required 0 00", busy_w[1], grant_w[1]);
            end
         end
      end
      checks++;
      if (!acked || !second) begin
         errors++; $display("FAIL rl4_summary: ack=%0d second=%0d required 1 1", acked, second);
      end
      wait_idle();
   endtask

   task automatic test_halt();
      int a, ack0 = -1, ack1 = -1, extra = 0;
      halt = 1; m0_addr = 32'h400; m0_strb = '0; m0_req = 1;
      for (int i = 0; i < 10; i++) begin
         run_cycle();
         checks++;
         if (address_w !== '0 || busy_w !== 2'b00) begin
            errors++; $display("FAIL halt_block: got busy %b required 00", busy_w);
         end
      end
      halt = 0;
      run_cycle();
      a = cyc;
      checks++;
      if (address_w[0] !== 32'h400 || address_w[1] !== 32'h400) begin
         errors++;
         $display("FAIL halt_release: got %h %h required 00000400", address_w[0], address_w[1]);
      end
      run_cycle();
      halt = 1;
      for (int i = 0; i < 8; i++) begin
         run_cycle();
         if (m0_ack_w[0]) ack0 = cyc - a;
         if (m0_ack_w[1]) ack1 = cyc - a;
         if (address_w != '0) extra++;
      end
      checks++;
      if (ack0 != 2 || ack1 != 5 || extra != 0) begin
         errors++;
         $display("FAIL halt_inflight: got ack A+%0d/A+%0d beats %0d required A+2/A+5 0", ack0,
                  ack1, extra);
      end
      wait_idle();
   endtask

   task automatic test_reset_mid();
      int a = -1, acks0 = 0, acks1 = 0;
      m0_addr = 32'h10; m1_addr = 32'h20; m0_strb = '0; m1_strb = '0;
      m0_req = 1; m1_req = 1;
      for (int i = 0; i < 10 && a < 0; i++) begin
         run_cycle();
         if (address_w[1] != '0) a = cyc;
      end
      run_cycle();
      run_cycle();
      reset_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({address_w[k], data_w[k], we_ram_w[k], we_w[k], grant_w[k], busy_w[k], m0_ack_w[k],
              m1_ack_w[k], m0_rdata_w[k], m1_rdata_w[k]} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs inst%0d: got nonzero outputs, required all 0", k);
         end
      end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      reset_n = 1'b1;
      run_cycle();
      checks++;
      if (grant_w[0] !== 2'b01 || grant_w[1] !== 2'b01 || address_w[0] !== 32'h10) begin
         errors++;
         $display("FAIL reset_rearb: got %b %b %h required 01 01 00000010", grant_w[0],
                  grant_w[1], address_w[0]);
      end
      m0_req = 0; m1_req = 0;
      for (int i = 0; i < 10; i++) begin
         run_cycle();
         acks0 += m0_ack_w[0] + m1_ack_w[0];
         acks1 += m0_ack_w[1] + m1_ack_w[1];
      end
      checks++;
      if (acks0 != 1 || acks1 != 1) begin
         errors++; $display("FAIL reset_acks: got %0d/%0d required 1/1", acks0, acks1);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         m0_req = ($urandom_range(0, 3) != 0);
         m1_req = ($urandom_range(0, 3) != 0);
         halt = ($urandom_range(0, 9) == 0);
         m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
         m0_strb = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
         m1_strb = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
         data_in = $urandom;
         run_cycle();
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (address_w[k] !== e_addr[k] || data_w[k] !== e_data[k] ||
                we_ram_w[k] !== e_strb[k] || we_w[k] !== (|e_strb[k])) begin
               errors++;
               $display("FAIL rand_bus inst%0d cyc%0d: got %h %h %h required %h %h %h", k, cyc,
                        address_w[k], data_w[k], we_ram_w[k], e_addr[k], e_data[k], e_strb[k]);
            end
            checks++;
            if (grant_w[k] !== e_grant[k] || busy_w[k] !== e_busy[k]) begin
               errors++;
               $display("FAIL rand_grant inst%0d cyc%0d: got %b %b required %b %b", k, cyc,
                        grant_w[k], busy_w[k], e_grant[k], e_busy[k]);
            end
            checks++;
            if ({m1_ack_w[k], m0_ack_w[k]} !== e_ack[k]) begin
               errors++;
               $display("FAIL rand_ack inst%0d cyc%0d: got %b%b required %b", k, cyc,
                        m1_ack_w[k], m0_ack_w[k], e_ack[k]);
            end
            if (!(e_ack[k][0] && !e_rdchk[k])) begin
               checks++;
               if (m0_rdata_w[k] !== (e_ack[k][0] ? e_rd[k] : 32'h0)) begin
                  errors++;
                  $display("FAIL rand_rdata0 inst%0d cyc%0d: got %h required %h", k, cyc,
                           m0_rdata_w[k], e_ack[k][0] ? e_rd[k] : 32'h0);
               end
            end
            if (!(e_ack[k][1] && !e_rdchk[k])) begin
               checks++;
               if (m1_rdata_w[k] !== (e_ack[k][1] ? e_rd[k] : 32'h0)) begin
                  errors++;
                  $display("FAIL rand_rdata1 inst%0d cyc%0d: got %h required %h", k, cyc,
                           m1_rdata_w[k], e_ack[k][1] ? e_rd[k] : 32'h0);
               end
            end
         end
      end
      wait_idle();
   endtask

   initial begin
      #1;
      test_reset();
      test_read_rl1();
      test_write_m1();
      test_back_to_back();
      test_rl4();
      test_halt();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the shared system memory/peripheral bus.
- Master 0 is the soft CPU bus adapter. Master 1 is a secondary master, such as a debug loader or DMA.
- Each granted request becomes one single-cycle address/strobe beat on the shared bus.
- Read data is captured after a fixed ReadLatency and handed back with a one-cycle ack.
- Fairness between masters is round-robin. A system-level halt blocks new grants.

Parameters:
- address_width, 32, width of all address ports.
- ReadLatency, 1, cycles from the address beat to valid data_i; legal range 1..15.

Ports:
- clk_i  in  1  system clock
- reset_ni  in  1  asynchronous, active-low reset
- halt_i  in  1  high blocks new grants; an in-flight transaction still completes
- m0_req_i  in  1  master 0 request
- m0_addr_i  in  address_width  master 0 address
- m0_wdata_i  in  32  master 0 write data
- m0_strb_i  in  4  master 0 byte write strobes; 0 means read
- m0_ack_o  out  1  master 0 completion pulse
- m0_rdata_o  out  32  master 0 read data, valid while m0_ack_o is high
- m1_req_i, m1_addr_i, m1_wdata_i, m1_strb_i, m1_ack_o, m1_rdata_o: identical to master 0, for master 1
- address_o  out  address_width  bus address; nonzero only during the address beat
- data_o  out  32  bus write data
- we_ram_o  out  4  bus byte strobes
- we_o  out  1  bus write enable = OR of we_ram_o
- data_i  in  32  bus read data
- grant_o  out  2  one-hot owner of the current transaction; 00 when idle
- busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset, asynchronous, reset_ni low: all outputs go to 0 immediately.
  - state=IDLE, latency counter=0, last_grant=1, so master 0 wins the first tie.
  - Any transaction in flight is abandoned and no ack is issued.
- States: IDLE, ADDR, WAIT, DONE. Call the ADDR cycle A.
- IDLE, entry condition:
  - Requests are sampled only in IDLE, and only when halt_i=0.
  - With halt_i=1, the block stays in IDLE and ignores requests.
- IDLE, selection:
  - Only one req high: grant that master.
  - Both high: grant the master that is not last_grant.
- IDLE, on grant:
  - Register the winner's addr, wdata and strb.
  - Set grant_o and last_grant.
  - Go to ADDR.
- ADDR (cycle A), exactly one cycle:
  - address_o, data_o and we_ram_o carry the registered values; we_o=|strb.
  - Load counter=ReadLatency-1.
  - Next state is DONE if ReadLatency=1, else WAIT.
- WAIT:
  - Counter decrements by 1 per cycle.
  - Go to DONE on the cycle the counter is 1.
  - Net effect: the state is DONE in cycle A+ReadLatency.
- DONE (cycle A+ReadLatency):
  - Capture data_i into the read-data register at the end of the cycle.
  - Next state is IDLE.
- Ack, cycle A+ReadLatency+1:
  - The granted master's ack_o is high for exactly one cycle, with rdata_o holding the captured data.
  - State is IDLE in this cycle and may grant again, so the next address beat is at A+ReadLatency+2.
- Outputs outside their windows:
  - Outside ADDR: address_o=0, data_o=0, we_ram_o=0, we_o=0.
  - Outside the ack cycle: mX_rdata_o=0 and mX_ack_o=0.
  - grant_o is held from ADDR through DONE and cleared in the ack cycle.
- Writes: same sequencing and timing as reads; ack is issued; rdata_o content is don't-care.
- Throughput: one transaction per ReadLatency+2 cycles.
- Master rules:
  - Master rule: hold req, addr, wdata and strb stable until ack.
  - If req drops after grant: the transaction still completes and ack is still pulsed.
  - Requests are captured in IDLE, so input changes after grant have no effect.
- halt_i asserted mid-transaction: no effect until the block returns to IDLE.
- Back-to-back with both masters requesting continuously: grants strictly alternate 0,1,0,1,...
- Single master requesting continuously: it is granted every ReadLatency+2 cycles.
- Never more than one transaction in flight. Never more than one ack per transaction. Never both acks in the same cycle.

Test Plan:
- Reset release, ReadLatency=1, m0 read of addr 0x100, bus returns data_i=0xDEADBEEF in cycle A+1:
  - address_o=0x100 only in cycle A.
  - m0_ack_o high in A+2 with m0_rdata_o=0xDEADBEEF.
  - m1_ack_o stays 0.
- m1 write, addr 0x2000, wdata 0x12345678, strb 0xF:
  - Single beat with we_o=1, we_ram_o=0xF, data_o=0x12345678.
  - m1_ack_o pulses in A+2.
  - Bus is idle otherwise.
- Both req held high for 6 transactions:
  - grant_o sequence 01,10,01,10,01,10.
  - Address beats 3 cycles apart.
- ReadLatency=4, m0 read:
  - state goes ADDR, WAIT x3, DONE.
  - data_i sampled in A+4, ack in A+5.
  - Next beat no earlier than A+6.
- halt_i high with m0_req high:
  - No address beat for 10 cycles.
  - halt_i low leads to IDLE, then ADDR on the next edge.
  - halt_i raised during WAIT still lets that transaction ack.
- reset_ni pulled low during WAIT:
  - All outputs 0 immediately and no ack.
  - After release, a pending request is re-arbitrated with m0 winning the tie.
